// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - op encodings and default parameters for the program-counter sequencer
package pc_pkg;

  typedef enum logic [2:0] {
    OP_INC    = 3'b000,
    OP_LOAD   = 3'b001,
    OP_BRANCH = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100
  } pc_op_e;

  localparam int PC_WIDTH       = 12;
  localparam int PC_OFS_W       = 8;
  localparam int PC_STACK_DEPTH = 4;
  localparam int PC_RESET_VEC   = 0;

endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - return-address stack; push/pop are already qualified by the caller
module pc_ret_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  // count is never DEPTH when writing, so truncating it to the index width is safe
  assign wr_idx = count[IW-1:0];
  assign rd_idx = wr_idx - 1'b1;
  assign top    = mem[rd_idx];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      count       <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with inc/load/branch/call/ret and a return stack
module pc_seq
  import pc_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter int               OFS_W       = PC_OFS_W,
  parameter int               STACK_DEPTH = PC_STACK_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(PC_RESET_VEC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic [OFS_W-1:0] offset,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             wrap,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] ofs_ext;
  logic [WIDTH-1:0] stk_top;
  logic             push;
  logic             pop;
  logic             active;

  assign q_inc   = q + 1'b1;
  assign ofs_ext = WIDTH'($signed(offset));
  assign carry   = &q;
  assign active  = !reset && !hold;
  assign push    = active && (op == OP_CALL) && !stack_full;
  assign pop     = active && (op == OP_RET) && !stack_empty;

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (q_inc),
    .top       (stk_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      q         <= RESET_VEC;
      wrap      <= 1'b0;
      stack_err <= 1'b0;
    end else if (hold) begin
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (op)
        OP_LOAD:   q <= d;
        OP_BRANCH: q <= q + ofs_ext;
        OP_CALL: begin
          q <= d;
          if (stack_full) stack_err <= 1'b1;
        end
        OP_RET: begin
          // an empty-stack return degrades to INC so execution keeps moving
          if (stack_empty) begin
            q         <= q_inc;
            wrap      <= carry;
            stack_err <= 1'b1;
          end else begin
            q <= stk_top;
          end
        end
        default: begin
          q    <= q_inc;
          wrap <= carry;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed self-checking bench for pc_seq
module tb_pc_seq;

  logic        clock;
  logic        reset;
  logic        hold;
  logic [2:0]  op;
  logic [11:0] d;
  logic [7:0]  offset;
  logic [11:0] q;
  logic        carry;
  logic        wrap;
  logic        stack_full;
  logic        stack_empty;
  logic        stack_err;

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] INC = 3'b000, LOAD = 3'b001, BRANCH = 3'b010, CALL = 3'b011, RET = 3'b100;

  pc_seq dut (
    .clock       (clock),
    .reset       (reset),
    .hold        (hold),
    .op          (op),
    .d           (d),
    .offset      (offset),
    .q           (q),
    .carry       (carry),
    .wrap        (wrap),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic [2:0] o, input logic [11:0] dv, input logic [7:0] ov);
    op = o; d = dv; offset = ov;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; hold = 1'b0;
    step(INC, 12'h000, 8'h00);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b1;
    step(CALL, 12'h777, 8'h11);
    reset = 1'b0; hold = 1'b0;
    tests++; if (q !== 12'h000) begin fails++; $display("FAIL reset_q got=%h exp=000", q); end
    tests++; if (carry !== 1'b0 || wrap !== 1'b0) begin fails++; $display("FAIL reset_carry_wrap got=%b%b exp=00", carry, wrap); end
    tests++; if (stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_err !== 1'b0)
      begin fails++; $display("FAIL reset_stack got e/f/err=%b%b%b exp=100", stack_empty, stack_full, stack_err); end
  endtask

  task automatic test_inc_wrap();
    do_reset();
    step(LOAD, 12'hFFE, 8'h00);
    tests++; if (q !== 12'hFFE || carry !== 1'b0) begin fails++; $display("FAIL load_ffe got q=%h c=%b exp FFE 0", q, carry); end
    step(INC, 12'h000, 8'h00);
    tests++; if (q !== 12'hFFF || carry !== 1'b1 || wrap !== 1'b0) begin fails++; $display("FAIL inc_fff got q=%h c=%b w=%b exp FFF 1 0", q, carry, wrap); end
    step(INC, 12'h000, 8'h00);
    tests++; if (q !== 12'h000 || carry !== 1'b0 || wrap !== 1'b1) begin fails++; $display("FAIL inc_wrap got q=%h c=%b w=%b exp 000 0 1", q, carry, wrap); end
    step(INC, 12'h000, 8'h00);
    tests++; if (q !== 12'h001 || wrap !== 1'b0) begin fails++; $display("FAIL wrap_one_cycle got q=%h w=%b exp 001 0", q, wrap); end
    step(3'b110, 12'h000, 8'h00);
    tests++; if (q !== 12'h002) begin fails++; $display("FAIL reserved_op got=%h exp=002", q); end
  endtask

  task automatic test_branch();
    do_reset();
    step(LOAD, 12'h010, 8'h00);
    step(BRANCH, 12'h000, 8'hFD);
    tests++; if (q !== 12'h00D) begin fails++; $display("FAIL branch_neg got=%h exp=00D", q); end
    step(LOAD, 12'hFFE, 8'h00);
    step(BRANCH, 12'h000, 8'h05);
    tests++; if (q !== 12'h003 || wrap !== 1'b0) begin fails++; $display("FAIL branch_wrap got q=%h w=%b exp 003 0", q, wrap); end
    step(BRANCH, 12'h000, 8'h80);
    tests++; if (q !== 12'hF83) begin fails++; $display("FAIL branch_min got=%h exp=F83", q); end
  endtask

  task automatic test_call_ret();
    logic [11:0] exp_ret [4];
    exp_ret[0] = 12'h401; exp_ret[1] = 12'h301; exp_ret[2] = 12'h201; exp_ret[3] = 12'h101;
    do_reset();
    step(LOAD, 12'h100, 8'h00);
    for (int i = 0; i < 4; i++) step(CALL, 12'h200 + 12'(i) * 12'h100, 8'h00);
    tests++; if (q !== 12'h500 || stack_full !== 1'b1 || stack_err !== 1'b0)
      begin fails++; $display("FAIL call_fill got q=%h full=%b err=%b exp 500 1 0", q, stack_full, stack_err); end
    step(CALL, 12'h600, 8'h00);
    tests++; if (q !== 12'h600 || stack_err !== 1'b1 || stack_full !== 1'b1)
      begin fails++; $display("FAIL call_overflow got q=%h err=%b full=%b exp 600 1 1", q, stack_err, stack_full); end
    for (int i = 0; i < 4; i++) begin
      step(RET, 12'h000, 8'h00);
      tests++; if (q !== exp_ret[i]) begin fails++; $display("FAIL ret_%0d got=%h exp=%h", i, q, exp_ret[i]); end
    end
    tests++; if (stack_empty !== 1'b1 || stack_err !== 1'b1)
      begin fails++; $display("FAIL ret_drained got empty=%b err=%b exp 1 1", stack_empty, stack_err); end
  endtask

  task automatic test_ret_empty();
    do_reset();
    step(LOAD, 12'h0FF, 8'h00);
    step(RET, 12'h000, 8'h00);
    tests++; if (q !== 12'h100 || stack_err !== 1'b1 || stack_empty !== 1'b1)
      begin fails++; $display("FAIL ret_empty got q=%h err=%b empty=%b exp 100 1 1", q, stack_err, stack_empty); end
    for (int i = 0; i < 10; i++) begin
      step(INC, 12'h000, 8'h00);
      tests++; if (stack_err !== 1'b1) begin fails++; $display("FAIL err_sticky_%0d got=%b exp=1", i, stack_err); end
    end
    tests++; if (q !== 12'h10A) begin fails++; $display("FAIL ret_empty_incs got=%h exp=10A", q); end
    step(LOAD, 12'hFFF, 8'h00);
    step(RET, 12'h000, 8'h00);
    tests++; if (q !== 12'h000 || wrap !== 1'b1) begin fails++; $display("FAIL ret_empty_wrap got q=%h w=%b exp 000 1", q, wrap); end
  endtask

  task automatic test_hold();
    do_reset();
    step(LOAD, 12'h123, 8'h00);
    step(CALL, 12'h456, 8'h00);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(LOAD, 12'hABC, 8'h00);
      tests++; if (q !== 12'h456 || stack_empty !== 1'b0 || stack_err !== 1'b0 || wrap !== 1'b0)
        begin fails++; $display("FAIL hold_%0d got q=%h empty=%b err=%b w=%b exp 456 0 0 0", i, q, stack_empty, stack_err, wrap); end
    end
    hold = 1'b0;
    step(RET, 12'h000, 8'h00);
    tests++; if (q !== 12'h124 || stack_empty !== 1'b1) begin fails++; $display("FAIL hold_then_ret got q=%h empty=%b exp 124 1", q, stack_empty); end
    step(LOAD, 12'hFFF, 8'h00);
    step(INC, 12'h000, 8'h00);
    hold = 1'b1;
    step(INC, 12'h000, 8'h00);
    hold = 1'b0;
    tests++; if (q !== 12'h000 || wrap !== 1'b0) begin fails++; $display("FAIL hold_clears_wrap got q=%h w=%b exp 000 0", q, wrap); end
  endtask

  task automatic test_reset_override();
    do_reset();
    step(RET, 12'h000, 8'h00);
    step(LOAD, 12'hFFF, 8'h00);
    step(CALL, 12'h020, 8'h00);
    step(CALL, 12'h030, 8'h00);
    reset = 1'b1;
    step(RET, 12'h000, 8'h00);
    reset = 1'b0;
    tests++; if (q !== 12'h000 || stack_empty !== 1'b1 || stack_err !== 1'b0 || wrap !== 1'b0)
      begin fails++; $display("FAIL reset_override got q=%h empty=%b err=%b w=%b exp 000 1 0 0", q, stack_empty, stack_err, wrap); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(LOAD, 12'h050, 8'h00);
    step(CALL, 12'h060, 8'h00);
    step(RET, 12'h000, 8'h00);
    tests++; if (q !== 12'h051) begin fails++; $display("FAIL b2b_ret1 got=%h exp=051", q); end
    step(CALL, 12'h070, 8'h00);
    step(CALL, 12'h080, 8'h00);
    step(RET, 12'h000, 8'h00);
    tests++; if (q !== 12'h071) begin fails++; $display("FAIL b2b_ret2 got=%h exp=071", q); end
    step(RET, 12'h000, 8'h00);
    tests++; if (q !== 12'h052 || stack_empty !== 1'b1 || stack_err !== 1'b0)
      begin fails++; $display("FAIL b2b_ret3 got q=%h empty=%b err=%b exp 052 1 0", q, stack_empty, stack_err); end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; op = INC; d = '0; offset = '0;
    test_reset();
    test_inc_wrap();
    test_branch();
    test_call_ret();
    test_ret_empty();
    test_hold();
    test_reset_override();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
